clkgen_seq: RTL and testbench

CLKGEN_SEQ -- requirements
Module: clkgen_seq

---
 rtl/clkgen_seq.sv | 169 ++++++++++++++++
 tb/tb_clkgen_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_seq.sv
// rtl/clkgen_seq.sv - PLL-lock filtered, staggered channel reset release with per-channel clock-enable dividers.
// Optional lock-loss event counter enabled by CLKGEN_SEQ_LOSS_CNT_EN.
module clkgen_seq #(
  parameter int NumChannels      = 4,
  parameter int DivWidth         = 8,
  parameter int LockFilterCycles = 16,
  parameter int ResetStagger     = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            pll_locked_i,
  input  logic [NumChannels*DivWidth-1:0] div_i,
  output logic [NumChannels-1:0]          chan_rst_no,
  output logic [NumChannels-1:0]          chan_en_o,
  output logic [1:0]                      state_o,
  output logic [7:0]                      lock_loss_cnt_o
);

  localparam int FiltW = $clog2(LockFilterCycles + 1);
  localparam int StagW = (ResetStagger > 1) ? $clog2(ResetStagger) : 1;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_RELEASE   = 2'b01,
    ST_RUN       = 2'b10
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_lock_s;
  logic [FiltW-1:0]       r_filt;
  logic [StagW-1:0]       r_stag;
  logic [NumChannels-1:0] r_rel;
  logic [DivWidth-1:0]    r_cnt [NumChannels];
  logic [DivWidth-1:0]    r_act [NumChannels];
  logic [NumChannels-1:0] w_en;
  logic                   w_lock_loss;
  logic                   w_filt_done;
  logic                   w_stag_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked_i;
      r_lock_s <= r_sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_WAIT_LOCK;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_loss = 1'b0;
    w_filt_done = r_lock_s && (r_filt == FiltW'(LockFilterCycles - 1));
    w_stag_done = (r_stag == StagW'(ResetStagger - 1));
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_filt_done) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_lock_loss = 1'b1;
        end else if (r_rel[NumChannels-1]) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_lock_loss = 1'b1;
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filt <= '0;
    end else if (r_state != ST_WAIT_LOCK || !r_lock_s || w_filt_done) begin
      r_filt <= '0;
    end else begin
      r_filt <= r_filt + FiltW'(1);
    end
  end

  // Channels release in index order, so the released set is always a
  // contiguous run from bit 0 and grows by one shift per stagger period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rel  <= '0;
      r_stag <= '0;
    end else if (w_lock_loss) begin
      r_rel  <= '0;
      r_stag <= '0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          r_stag <= '0;
          r_rel  <= w_filt_done ? NumChannels'(1) : '0;
        end
        ST_RELEASE: begin
          if (!r_rel[NumChannels-1]) begin
            if (w_stag_done) begin
              r_stag <= '0;
              r_rel  <= r_rel | (r_rel << 1);
            end else begin
              r_stag <= r_stag + StagW'(1);
            end
          end
        end
        default: r_stag <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumChannels; k++) begin
        r_cnt[k] <= '0;
        r_act[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumChannels; k++) begin
        if (!r_rel[k] || w_en[k]) begin
          r_cnt[k] <= '0;
          r_act[k] <= div_i[k*DivWidth +: DivWidth];
        end else begin
          r_cnt[k] <= r_cnt[k] + DivWidth'(1);
        end
      end
    end
  end

  always_comb begin
    w_en = '0;
    for (int k = 0; k < NumChannels; k++) begin
      w_en[k] = r_rel[k] && (r_cnt[k] == r_act[k]);
    end
  end

`ifdef CLKGEN_SEQ_LOSS_CNT_EN
  logic [7:0] r_loss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_loss <= '0;
    end else if (w_lock_loss && r_loss != 8'hFF) begin
      r_loss <= r_loss + 8'd1;
    end
  end

  assign lock_loss_cnt_o = r_loss;
`else
  assign lock_loss_cnt_o = '0;
`endif

  assign chan_rst_no = r_rel;
  assign chan_en_o   = w_en;
  assign state_o     = r_state;

endmodule

// File: tb/tb_clkgen_seq.sv
// tb/tb_clkgen_seq.sv - self-checking bench for clkgen_seq against a schedule-level reference model.
module tb_clkgen_seq;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int LFC = 16;
  localparam int STG = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll = 1'b0;
  logic [NCH*DW-1:0] div = '0;
  logic [NCH-1:0]    chan_rst_no;
  logic [NCH-1:0]    chan_en_o;
  logic [1:0]        state_o;
  logic [7:0]        lock_loss_cnt_o;

  clkgen_seq #(
    .NumChannels(NCH), .DivWidth(DW), .LockFilterCycles(LFC), .ResetStagger(STG)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(pll), .div_i(div),
    .chan_rst_no(chan_rst_no), .chan_en_o(chan_en_o),
    .state_o(state_o), .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0d expected=%0d", name, ecnt, act, exp);
    end
  endtask

  // Reference model: mode, edges since channel 0 release, and cycles left until each channel's next pulse.
  int m_mode, m_run, m_t, m_loss;
  bit m_s1, m_s2;
  int m_left [NCH];

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_t = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
    for (int k = 0; k < NCH; k++) m_left[k] = 0;
  endfunction

  function automatic logic [NCH-1:0] exp_rst();
    logic [NCH-1:0] r = '0;
    for (int k = 0; k < NCH; k++) r[k] = (m_mode != 0) && (m_t >= k * STG);
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_en();
    logic [NCH-1:0] r = exp_rst();
    for (int k = 0; k < NCH; k++) r[k] = r[k] && (m_left[k] == 0);
    return r;
  endfunction

  function automatic int exp_loss();
`ifdef CLKGEN_SEQ_LOSS_CNT_EN
    return (m_loss > 255) ? 255 : m_loss;
`else
    return 0;
`endif
  endfunction

  function automatic void model_edge();
    logic [NCH-1:0] rel_old = exp_rst();
    int dk;
    if (m_mode == 0) begin
      if (m_s2) begin
        m_run++;
        if (m_run == LFC) begin m_mode = 1; m_t = 0; m_run = 0; end
      end else m_run = 0;
    end else if (!m_s2) begin
      m_mode = 0; m_loss++; m_run = 0; m_t = 0;
    end else begin
      m_t++;
      if (m_mode == 1 && m_t == (NCH - 1) * STG + 1) m_mode = 2;
    end
    m_s2 = m_s1;
    m_s1 = pll;
    for (int k = 0; k < NCH; k++) begin
      dk = int'(div[k*DW +: DW]);
      if (!rel_old[k] || m_left[k] == 0) m_left[k] = dk;
      else m_left[k]--;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    ecnt++;
    #1;
    chk("chan_rst_no", int'(chan_rst_no), int'(exp_rst()));
    chk("chan_en_o", int'(chan_en_o), int'(exp_en()));
    chk("state_o", int'(state_o), m_mode);
    chk("lock_loss_cnt_o", int'(lock_loss_cnt_o), exp_loss());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("reset_rst", int'(chan_rst_no), 0);
    chk("reset_en", int'(chan_en_o), 0);
    chk("reset_state", int'(state_o), 0);
    chk("reset_loss", int'(lock_loss_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int             edge_no;
    logic [NCH-1:0] rst;
    int             st;
  } vec_t;
  vec_t tbl [8];

  task automatic run_table(input int upto);
    for (int e = 1; e <= upto; e++) begin
      cycle();
      for (int i = 0; i < 8; i++) begin
        if (tbl[i].edge_no == e) begin
          chk($sformatf("seq_rst_e%0d", e), int'(chan_rst_no), int'(tbl[i].rst));
          chk($sformatf("seq_state_e%0d", e), int'(state_o), tbl[i].st);
        end
      end
    end
  endtask

  task automatic find_pulse(output int at);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      cycle();
      if (chan_en_o[0]) at = ecnt;
    end
    if (at < 0) chk("pulse_timeout", 0, 1);
  endtask

  task automatic wait_state(input int st, input int bound);
    int n = 0;
    while (int'(state_o) != st && n < bound) begin cycle(); n++; end
    chk($sformatf("reach_state_%0d", st), int'(state_o), st);
  endtask

  int p1, p2, p3, p4, n;

  initial begin
    tbl[0] = '{17, 4'b0000, 0};
    tbl[1] = '{18, 4'b0001, 1};
    tbl[2] = '{21, 4'b0001, 1};
    tbl[3] = '{22, 4'b0011, 1};
    tbl[4] = '{26, 4'b0111, 1};
    tbl[5] = '{29, 4'b0111, 1};
    tbl[6] = '{30, 4'b1111, 1};
    tbl[7] = '{31, 4'b1111, 2};
    model_reset();
    div = {8'd2, 8'd5, 8'd0, 8'd3};

    // Power-up sequence with lock high from reset release.
    pll = 1'b1;
    do_reset();
    run_table(31);

    // Async reset while channel 1 is released, then a full repeat.
    do_reset();
    run_table(23);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst", int'(chan_rst_no), 0);
    chk("async_en", int'(chan_en_o), 0);
    chk("async_state", int'(state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_table(31);

    // One-cycle lock glitch with filter at 10 restarts the filter.
    do_reset();
    for (int i = 0; i < 12; i++) cycle();
    pll = 1'b0;
    cycle();
    pll = 1'b1;
    for (int i = 14; i <= 30; i++) cycle();
    chk("glitch_rst0_e30", int'(chan_rst_no[0]), 0);
    cycle();
    chk("glitch_rst0_e31", int'(chan_rst_no[0]), 1);

    // Divider periods and div change applied only at wrap.
    wait_state(2, 40);
    chk("d0_const_en", int'(chan_en_o[1]), 1);
    find_pulse(p1);
    find_pulse(p2);
    chk("period_d3", p2 - p1, 4);
    cycle();
    div[7:0] = 8'd1;
    find_pulse(p3);
    chk("period_after_change", p3 - p2, 4);
    find_pulse(p4);
    chk("period_d1", p4 - p3, 2);

    // Lock loss in RUN.
    pll = 1'b0;
    cycle();
    chk("loss_e1_rst", int'(chan_rst_no), 15);
    cycle();
    chk("loss_e2_rst", int'(chan_rst_no), 15);
    cycle();
    chk("loss_e3_rst", int'(chan_rst_no), 0);
    chk("loss_e3_en", int'(chan_en_o), 0);
    chk("loss_e3_state", int'(state_o), 0);
`ifdef CLKGEN_SEQ_LOSS_CNT_EN
    chk("loss_e3_cnt", int'(lock_loss_cnt_o), 1);
`else
    chk("loss_e3_cnt", int'(lock_loss_cnt_o), 0);
`endif

    // Repeated lock losses drive the counter to saturation.
    for (int i = 0; i < 300; i++) begin
      pll = 1'b1;
      n = 0;
      while (!chan_rst_no[0] && n < 40) begin cycle(); n++; end
      if (!chan_rst_no[0]) chk("relock_timeout", 0, 1);
      pll = 1'b0;
      for (int j = 0; j < 3; j++) cycle();
    end
`ifdef CLKGEN_SEQ_LOSS_CNT_EN
    chk("loss_saturated", int'(lock_loss_cnt_o), 255);
`else
    chk("loss_saturated", int'(lock_loss_cnt_o), 0);
`endif

    // Randomized lock and divide activity against the model.
    do_reset();
    pll = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (pll) begin
        if ($urandom_range(0, 59) == 0) pll = 1'b0;
      end else if ($urandom_range(0, 2) == 0) pll = 1'b1;
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 15) == 0) div[k*DW +: DW] = DW'($urandom_range(0, 6));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
